// File: rtl/lcd_frame_scheduler_pkg.sv
// Shared definitions for the LCD frame scheduler: AHB encodings,
// LCD drive register indices and state encodings.
package lcd_frame_scheduler_pkg;

    // AHB transfer types
    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_BUSY   = 2'b01;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [1:0] TRANS_SEQ    = 2'b11;

    // AHB responses
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;
    localparam logic [1:0] RESP_RETRY = 2'b10;
    localparam logic [1:0] RESP_SPLIT = 2'b11;

    // Fixed transfer attributes
    localparam logic [2:0] SIZE_WORD    = 3'b010;
    localparam logic [2:0] BURST_SINGLE = 3'b000;

    // HPROT bits: [3] cacheable, [2] bufferable, [1] privileged, [0] data
    localparam logic [3:0] PROT_NOTCACHE = 4'b0000;
    localparam logic [3:0] PROT_UNBUF    = 4'b0000;
    localparam logic [3:0] PROT_USER     = 4'b0000;
    localparam logic [3:0] PROT_DATA     = 4'b0001;
    localparam logic [3:0] PROT_DEFAULT  = PROT_NOTCACHE | PROT_UNBUF | PROT_USER | PROT_DATA;

    // LCD drive register word indices
    localparam logic [7:0] REG_START    = 8'd8;
    localparam logic [7:0] REG_BR_MODE  = 8'd9;
    localparam logic [7:0] REG_BR_VALUE = 8'd10;

    // Top-level sequencer states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_MODE,
        ST_WR_VAL,
        ST_WR_GO,
        ST_WAIT_FRAME,
        ST_WR_STOP,
        ST_GAP,
        ST_DONE
    } state_t;

    // Bus phases of the single-write engine
    typedef enum logic [1:0] {
        PH_IDLE,
        PH_ADDR,
        PH_DATA
    } phase_t;

    // Byte address of a register given the block base and word index
    function automatic logic [31:0] reg_addr(input logic [31:0] base, input logic [7:0] idx);
        return base + {22'd0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/lcd_frame_scheduler_ahb_single_writer.sv
// Single NONSEQ AHB-lite write engine: takes one request, runs the
// address phase and the data phase, then pulses ack (with resp_err).
module lcd_frame_scheduler_ahb_single_writer
    import lcd_frame_scheduler_pkg::*;
#(
    parameter int W_ADDR = 32,
    parameter int W_DATA = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req,
    input  logic [W_ADDR-1:0] i_addr,
    input  logic [W_DATA-1:0] i_wdata,
    output logic              o_ack,
    output logic              o_resp_err,
    input  logic              i_hready,
    input  logic [1:0]        i_hresp,
    output logic [1:0]        o_htrans,
    output logic [W_ADDR-1:0] o_haddr,
    output logic              o_hwrite,
    output logic [2:0]        o_hsize,
    output logic [2:0]        o_hburst,
    output logic [3:0]        o_hprot,
    output logic [W_DATA-1:0] o_hwdata
);

    phase_t            r_phase;
    logic [1:0]        r_htrans;
    logic [W_ADDR-1:0] r_haddr;
    logic              r_hwrite;
    logic [2:0]        r_hsize;
    logic [2:0]        r_hburst;
    logic [3:0]        r_hprot;
    logic [W_DATA-1:0] r_hwdata;
    logic [W_DATA-1:0] r_wdata_q;
    logic              r_err_seen;
    logic              r_ack;
    logic              r_resp_err;

    // Address/data phase pipeline with registered bus outputs
    always_ff @(posedge i_clk) begin
        // NOTE: every register, data holding ones included, is cleared so the bus reads all-zero straight out of reset.
        if (i_rst) begin
            r_phase    <= PH_IDLE;
            r_htrans   <= TRANS_IDLE;
            r_haddr    <= '0;
            r_hwrite   <= 1'b0;
            r_hsize    <= '0;
            r_hburst   <= '0;
            r_hprot    <= '0;
            r_hwdata   <= '0;
            r_wdata_q  <= '0;
            r_err_seen <= 1'b0;
            r_ack      <= 1'b0;
            r_resp_err <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every branch reads the pre-edge state.
            r_hsize    <= SIZE_WORD;
            r_hburst   <= BURST_SINGLE;
            r_hprot    <= PROT_DEFAULT;
            r_ack      <= 1'b0;
            r_resp_err <= 1'b0;
            case (r_phase)
                PH_IDLE: begin
                    if (i_req) begin
                        r_htrans   <= TRANS_NONSEQ;
                        r_hwrite   <= 1'b1;
                        r_haddr    <= i_addr;
                        r_wdata_q  <= i_wdata;
                        r_err_seen <= 1'b0;
                        r_phase    <= PH_ADDR;
                    end
                end
                PH_ADDR: begin
                    // Address held until the slave accepts it
                    if (i_hready) begin
                        r_htrans <= TRANS_IDLE;
                        r_hwrite <= 1'b0;
                        r_hwdata <= r_wdata_q;
                        r_phase  <= PH_DATA;
                    end
                end
                PH_DATA: begin
                    // An error response may span a wait cycle; remember it
                    if (i_hresp != RESP_OKAY) begin
                        r_err_seen <= 1'b1;
                    end
                    if (i_hready) begin
                        r_ack      <= 1'b1;
                        r_resp_err <= r_err_seen | (i_hresp != RESP_OKAY);
                        r_phase    <= PH_IDLE;
                    end
                end
                default: r_phase <= PH_IDLE;
            endcase
        end
    end

    assign o_ack      = r_ack;
    assign o_resp_err = r_resp_err;
    assign o_htrans   = r_htrans;
    assign o_haddr    = r_haddr;
    assign o_hwrite   = r_hwrite;
    assign o_hsize    = r_hsize;
    assign o_hburst   = r_hburst;
    assign o_hprot    = r_hprot;
    assign o_hwdata   = r_hwdata;

endmodule

// File: rtl/lcd_frame_scheduler.sv
// LCD frame scheduler: AHB-lite master that programs the LCD drive
// registers per frame, counts pixel pairs, and steps brightness between frames.
module lcd_frame_scheduler
    import lcd_frame_scheduler_pkg::*;
#(
    parameter logic [31:0] LCD_BASE    = 32'h0000_0000,
    parameter int          FRAME_PAIRS = 196608,
    parameter int          W_PIX_CNT   = 18,
    parameter int          TIMEOUT     = 4095,
    parameter int          W_ADDR      = 32,
    parameter int          W_DATA      = 32
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              cmd_start,
    input  logic              cmd_abort,
    input  logic [7:0]        cfg_num_frames,
    input  logic              cfg_br_mode,
    input  logic [7:0]        cfg_br_start,
    input  logic [7:0]        cfg_br_step,
    input  logic [15:0]       cfg_gap,
    input  logic              lcd_valid,
    input  logic              M_HREADY,
    input  logic [1:0]        M_HRESP,
    output logic [1:0]        M_HTRANS,
    output logic [W_ADDR-1:0] M_HADDR,
    output logic              M_HWRITE,
    output logic [2:0]        M_HSIZE,
    output logic [2:0]        M_HBURST,
    output logic [3:0]        M_HPROT,
    output logic [W_DATA-1:0] M_HWDATA,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [7:0]        frame_idx
);

    localparam int                W_IDLE_CNT = $clog2(TIMEOUT + 1);
    localparam logic [W_PIX_CNT-1:0]  LAST_PIX   = W_PIX_CNT'(FRAME_PAIRS - 1);
    localparam logic [W_IDLE_CNT-1:0] LAST_IDLE  = W_IDLE_CNT'(TIMEOUT - 1);
    localparam logic [W_ADDR-1:0] ADDR_START = W_ADDR'(reg_addr(LCD_BASE, REG_START));
    localparam logic [W_ADDR-1:0] ADDR_MODE  = W_ADDR'(reg_addr(LCD_BASE, REG_BR_MODE));
    localparam logic [W_ADDR-1:0] ADDR_VALUE = W_ADDR'(reg_addr(LCD_BASE, REG_BR_VALUE));

    state_t                r_state;
    logic [7:0]            r_num_frames;
    logic                  r_br_mode;
    logic [7:0]            r_br;
    logic [7:0]            r_br_step;
    logic [15:0]           r_gap;
    logic [15:0]           r_gap_cnt;
    logic [W_PIX_CNT-1:0]  r_pix_cnt;
    logic [W_IDLE_CNT-1:0] r_idle_cnt;
    logic [7:0]            r_frame_idx;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_err;
    logic                  r_abort_pend;
    logic                  r_issued;

    logic                  w_req;
    logic [W_ADDR-1:0]     w_addr;
    logic [W_DATA-1:0]     w_wdata;
    logic                  w_ack;
    logic                  w_resp_err;
    logic                  w_abort;
    logic [8:0]            w_br_sum;
    logic [7:0]            w_br_next;

    // An abort seen now or earlier both end the run at the next STOP write
    assign w_abort   = cmd_abort | r_abort_pend;
    assign w_br_sum  = {1'b0, r_br} + {1'b0, r_br_step};
    assign w_br_next = w_br_sum[8] ? 8'hFF : w_br_sum[7:0];

    // Request one register write on entry to each write state
    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned (no latch).
        w_req   = 1'b0;
        w_addr  = '0;
        w_wdata = '0;
        case (r_state)
            ST_WR_MODE: begin
                w_req   = ~r_issued;
                w_addr  = ADDR_MODE;
                w_wdata = W_DATA'(r_br_mode);
            end
            ST_WR_VAL: begin
                w_req   = ~r_issued;
                w_addr  = ADDR_VALUE;
                w_wdata = W_DATA'(r_br);
            end
            ST_WR_GO: begin
                w_req   = ~r_issued;
                w_addr  = ADDR_START;
                w_wdata = W_DATA'(1'b1);
            end
            ST_WR_STOP: begin
                w_req   = ~r_issued;
                w_addr  = ADDR_START;
                w_wdata = '0;
            end
            default: ;
        endcase
    end

    // Run sequencer: frame loop, pixel counting, gap timing, status outputs
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state      <= ST_IDLE;
            r_num_frames <= '0;
            r_br_mode    <= 1'b0;
            r_br         <= '0;
            r_br_step    <= '0;
            r_gap        <= '0;
            r_gap_cnt    <= '0;
            r_pix_cnt    <= '0;
            r_idle_cnt   <= '0;
            r_frame_idx  <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_abort_pend <= 1'b0;
            r_issued     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_req) begin
                r_issued <= 1'b1;
            end
            if (w_ack) begin
                r_issued <= 1'b0;
            end
            if (cmd_abort && (r_state != ST_IDLE) && (r_state != ST_DONE)) begin
                r_abort_pend <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (cmd_start) begin
                        r_num_frames <= (cfg_num_frames == 8'd0) ? 8'd1 : cfg_num_frames;
                        r_br_mode    <= cfg_br_mode;
                        r_br         <= cfg_br_start;
                        r_br_step    <= cfg_br_step;
                        r_gap        <= cfg_gap;
                        r_frame_idx  <= '0;
                        r_busy       <= 1'b1;
                        r_err        <= 1'b0;
                        r_abort_pend <= 1'b0;
                        r_state      <= ST_WR_MODE;
                    end
                end
                ST_WR_MODE: begin
                    if (w_ack) begin
                        if (w_resp_err) begin
                            r_err   <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_state <= ST_WR_VAL;
                        end
                    end
                end
                ST_WR_VAL: begin
                    if (w_ack) begin
                        if (w_resp_err) begin
                            r_err   <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_state <= ST_WR_GO;
                        end
                    end
                end
                ST_WR_GO: begin
                    if (w_ack) begin
                        if (w_resp_err) begin
                            r_err   <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_pix_cnt  <= '0;
                            r_idle_cnt <= '0;
                            r_state    <= ST_WAIT_FRAME;
                        end
                    end
                end
                ST_WAIT_FRAME: begin
                    if (w_abort) begin
                        r_state <= ST_WR_STOP;
                    end else if (lcd_valid) begin
                        r_idle_cnt <= '0;
                        if (r_pix_cnt == LAST_PIX) begin
                            r_state <= ST_WR_STOP;
                        end else begin
                            r_pix_cnt <= r_pix_cnt + 1'b1;
                        end
                    end else if (r_idle_cnt == LAST_IDLE) begin
                        r_err   <= 1'b1;
                        r_state <= ST_WR_STOP;
                    end else begin
                        r_idle_cnt <= r_idle_cnt + 1'b1;
                    end
                end
                ST_WR_STOP: begin
                    if (w_ack) begin
                        if (w_resp_err) begin
                            r_err   <= 1'b1;
                            r_state <= ST_DONE;
                        end else if (r_err || w_abort || (r_frame_idx == r_num_frames - 8'd1)) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_gap_cnt <= '0;
                            r_state   <= ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    if (w_abort) begin
                        r_state <= ST_WR_STOP;
                    end else if (r_gap_cnt == r_gap) begin
                        r_frame_idx <= r_frame_idx + 8'd1;
                        r_br        <= w_br_next;
                        r_state     <= ST_WR_MODE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 16'd1;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    lcd_frame_scheduler_ahb_single_writer #(
        .W_ADDR (W_ADDR),
        .W_DATA (W_DATA)
    ) u_writer (
        .i_clk      (HCLK),
        .i_rst      (HRESET),
        .i_req      (w_req),
        .i_addr     (w_addr),
        .i_wdata    (w_wdata),
        .o_ack      (w_ack),
        .o_resp_err (w_resp_err),
        .i_hready   (M_HREADY),
        .i_hresp    (M_HRESP),
        .o_htrans   (M_HTRANS),
        .o_haddr    (M_HADDR),
        .o_hwrite   (M_HWRITE),
        .o_hsize    (M_HSIZE),
        .o_hburst   (M_HBURST),
        .o_hprot    (M_HPROT),
        .o_hwdata   (M_HWDATA)
    );

    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign frame_idx = r_frame_idx;

endmodule

// File: tb/tb_lcd_frame_scheduler.sv
// Directed bench for lcd_frame_scheduler with FRAME_PAIRS=8 and TIMEOUT=20.
module tb_lcd_frame_scheduler;

    localparam logic [31:0] A_START = 32'h20;
    localparam logic [31:0] A_MODE  = 32'h24;
    localparam logic [31:0] A_VALUE = 32'h28;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_start, cmd_abort;
    logic [7:0]  cfg_num_frames, cfg_br_start, cfg_br_step;
    logic        cfg_br_mode;
    logic [15:0] cfg_gap;
    logic        lcd_valid;
    logic        hready;
    logic [1:0]  hresp;
    logic [1:0]  htrans;
    logic [31:0] haddr, hwdata;
    logic        hwrite;
    logic [2:0]  hsize, hburst;
    logic [3:0]  hprot;
    logic        busy, done, err;
    logic [7:0]  frame_idx;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        int          acyc;
        int          dcyc;
    } wr_t;

    wr_t         wr_log[$];
    logic        mon_pend = 1'b0;
    logic [31:0] mon_addr = '0;
    int          mon_acyc = 0;

    lcd_frame_scheduler #(
        .LCD_BASE    (32'h0000_0000),
        .FRAME_PAIRS (8),
        .W_PIX_CNT   (18),
        .TIMEOUT     (20),
        .W_ADDR      (32),
        .W_DATA      (32)
    ) dut (
        .HCLK           (clk),
        .HRESET         (rst),
        .cmd_start      (cmd_start),
        .cmd_abort      (cmd_abort),
        .cfg_num_frames (cfg_num_frames),
        .cfg_br_mode    (cfg_br_mode),
        .cfg_br_start   (cfg_br_start),
        .cfg_br_step    (cfg_br_step),
        .cfg_gap        (cfg_gap),
        .lcd_valid      (lcd_valid),
        .M_HREADY       (hready),
        .M_HRESP        (hresp),
        .M_HTRANS       (htrans),
        .M_HADDR        (haddr),
        .M_HWRITE       (hwrite),
        .M_HSIZE        (hsize),
        .M_HBURST       (hburst),
        .M_HPROT        (hprot),
        .M_HWDATA       (hwdata)
    ,   .busy           (busy),
        .done           (done),
        .err            (err),
        .frame_idx      (frame_idx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Bus monitor: logs every completed write (address, data, phase cycles)
    always @(negedge clk) begin
        if (rst) begin
            mon_pend = 1'b0;
        end else begin
            if (mon_pend && hready) begin
                wr_log.push_back('{addr: mon_addr, data: hwdata, acyc: mon_acyc, dcyc: cyc});
                mon_pend = 1'b0;
            end
            if (htrans == 2'b10 && hready) begin
                mon_pend = 1'b1;
                mon_addr = haddr;
                mon_acyc = cyc;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] log_addr(input int i);
        if (i < wr_log.size()) return wr_log[i].addr;
        return 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] log_data(input int i);
        if (i < wr_log.size()) return wr_log[i].data;
        return 32'hDEAD_BEEF;
    endfunction

    function automatic int count_addr(input logic [31:0] a);
        int n = 0;
        foreach (wr_log[i]) if (wr_log[i].addr == a) n++;
        return n;
    endfunction

    task automatic check_write(input string tag, input int i, input logic [31:0] a, input logic [31:0] d);
        check({tag, "_addr"}, log_addr(i), a);
        check({tag, "_data"}, log_data(i), d);
    endtask

    task automatic set_cfg(input logic [7:0] nf, input logic mode, input logic [7:0] brs,
                           input logic [7:0] step, input logic [15:0] gap);
        cfg_num_frames = nf;
        cfg_br_mode    = mode;
        cfg_br_start   = brs;
        cfg_br_step    = step;
        cfg_gap        = gap;
    endtask

    // Caller sits just after a rising edge; leaves just after the accepting edge
    task automatic pulse_start(input string tag, input logic with_abort);
        wr_log.delete();
        cmd_start = 1'b1;
        cmd_abort = with_abort;
        @(posedge clk); #1;
        cmd_start = 1'b0;
        cmd_abort = 1'b0;
        check({tag, "_busy_on"}, busy, 1'b1);
    endtask

    // Returns on the rising edge right after the n-th write completed
    task automatic wait_writes(input string tag, input int n);
        logic ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(posedge clk);
            if (wr_log.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, "_wait_wr"}, ok, 1'b1);
    endtask

    task automatic feed(input int n);
        for (int i = 0; i < n; i++) begin
            lcd_valid = 1'b1;
            @(posedge clk); #1;
        end
        lcd_valid = 1'b0;
    endtask

    // Returns at the falling edge of the done cycle
    task automatic wait_done(input string tag);
        logic seen = 1'b0;
        int   busy_low = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (!busy) busy_low++;
        end
        check({tag, "_done"}, seen, 1'b1);
        check({tag, "_busy_held"}, busy_low, 0);
        check({tag, "_busy_off"}, busy, 1'b0);
    endtask

    task automatic wait_nonseq(input string tag, input logic [31:0] a);
        logic ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (htrans == 2'b10 && haddr == a) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, "_nonseq"}, ok, 1'b1);
    endtask

    initial begin
        int last_valid_cyc;
        int n;
        rst = 1'b1;
        cmd_start = 1'b0;
        cmd_abort = 1'b0;
        lcd_valid = 1'b0;
        hready = 1'b1;
        hresp = 2'b00;
        set_cfg(8'd0, 1'b0, 8'd0, 8'd0, 16'd0);

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_htrans", htrans, 2'b00);
        check("rst_hsize", hsize, 3'b000);
        check("rst_hprot", hprot, 4'b0000);
        check("rst_haddr", haddr, 32'h0);
        check("rst_status", {busy, done, err, frame_idx}, 11'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("post_rst_htrans", htrans, 2'b00);
        check("post_rst_hsize", hsize, 3'b010);
        check("post_rst_hburst", hburst, 3'b000);
        check("post_rst_hprot", hprot, 4'b0001);
        @(posedge clk); #1;

        // T1: single frame (num_frames=0 treated as 1), mode=1, br_start=40
        set_cfg(8'd0, 1'b1, 8'd40, 8'd0, 16'd0);
        pulse_start("t1", 1'b0);
        wait_writes("t1", 3);
        @(posedge clk); #1;
        feed(8);
        last_valid_cyc = cyc;
        wait_done("t1");
        check("t1_nwr", wr_log.size(), 4);
        check_write("t1_w0", 0, A_MODE, 32'd1);
        check_write("t1_w1", 1, A_VALUE, 32'd40);
        check_write("t1_w2", 2, A_START, 32'd1);
        check_write("t1_w3", 3, A_START, 32'd0);
        check("t1_stop_after_pix", (wr_log.size() == 4) && (wr_log[3].acyc >= last_valid_cyc), 1'b1);
        check("t1_err", err, 1'b0);
        check("t1_fidx", frame_idx, 8'd0);
        @(posedge clk); #1;
        check("t1_done_pulse", done, 1'b0);

        // T2: three frames, saturating brightness, gap=5; abort with start is ignored
        set_cfg(8'd3, 1'b0, 8'd200, 8'd30, 16'd5);
        pulse_start("t2", 1'b1);
        for (int k = 0; k < 3; k++) begin
            wait_writes("t2", 4 * k + 3);
            @(posedge clk); #1;
            check($sformatf("t2_fidx%0d", k), frame_idx, k[7:0]);
            feed(8);
        end
        wait_done("t2");
        check("t2_nwr", wr_log.size(), 12);
        check_write("t2_val0", 1, A_VALUE, 32'd200);
        check_write("t2_val1", 5, A_VALUE, 32'd230);
        check_write("t2_val2", 9, A_VALUE, 32'd255);
        check_write("t2_mode1", 4, A_MODE, 32'd0);
        check_write("t2_stop2", 11, A_START, 32'd0);
        if (wr_log.size() == 12) begin
            check("t2_gap0", (wr_log[4].acyc - wr_log[3].dcyc - 1) >= 5, 1'b1);
            check("t2_gap1", (wr_log[8].acyc - wr_log[7].dcyc - 1) >= 5, 1'b1);
        end
        check("t2_fidx_end", frame_idx, 8'd2);
        @(posedge clk); #1;

        // T3: 3 address-phase and 2 data-phase wait states on the BR_MODE write
        set_cfg(8'd1, 1'b1, 8'd99, 8'd0, 16'd0);
        hready = 1'b0;
        pulse_start("t3", 1'b0);
        wait_nonseq("t3", A_MODE);
        for (int s = 0; s < 2; s++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check($sformatf("t3_astall%0d", s), {htrans, haddr}, {2'b10, A_MODE});
        end
        @(posedge clk); #1;
        hready = 1'b1;
        @(negedge clk);
        check("t3_aaccept", htrans, 2'b10);
        @(posedge clk); #1;
        hready = 1'b0;
        for (int s = 0; s < 2; s++) begin
            @(negedge clk);
            check($sformatf("t3_dstall%0d", s), {htrans, hwdata}, {2'b00, 32'd1});
            @(posedge clk); #1;
        end
        hready = 1'b1;
        wait_writes("t3", 3);
        @(posedge clk); #1;
        feed(8);
        wait_done("t3");
        check("t3_nwr", wr_log.size(), 4);
        check("t3_mode_once", count_addr(A_MODE), 1);
        check_write("t3_w0", 0, A_MODE, 32'd1);
        check_write("t3_w1", 1, A_VALUE, 32'd99);
        @(posedge clk); #1;

        // T4: ERROR response on the BR_VALUE data phase
        set_cfg(8'd1, 1'b0, 8'd77, 8'd0, 16'd0);
        pulse_start("t4", 1'b0);
        wait_nonseq("t4", A_VALUE);
        @(posedge clk); #1;
        hready = 1'b0;
        hresp  = 2'b01;
        @(posedge clk); #1;
        hready = 1'b1;
        @(posedge clk); #1;
        hresp  = 2'b00;
        wait_done("t4");
        check("t4_err", err, 1'b1);
        check("t4_nwr", wr_log.size(), 2);
        check("t4_no_start", count_addr(A_START), 0);
        @(posedge clk); #1;
        check("t4_err_sticky", err, 1'b1);

        // T5: abort after 3 pixels of frame 0; next start clears err
        set_cfg(8'd3, 1'b1, 8'd10, 8'd5, 16'd2);
        pulse_start("t5", 1'b0);
        check("t5_err_clear", err, 1'b0);
        wait_writes("t5", 3);
        @(posedge clk); #1;
        feed(3);
        cmd_abort = 1'b1;
        @(posedge clk); #1;
        cmd_abort = 1'b0;
        wait_done("t5");
        check("t5_nwr", wr_log.size(), 4);
        check_write("t5_stop", 3, A_START, 32'd0);
        check("t5_fidx", frame_idx, 8'd0);
        check("t5_err", err, 1'b0);
        @(posedge clk); #1;

        // T6: lcd_valid stuck low after 3 pixels -> timeout 20 cycles later
        set_cfg(8'd1, 1'b0, 8'd5, 8'd0, 16'd0);
        pulse_start("t6", 1'b0);
        wait_writes("t6", 3);
        @(posedge clk); #1;
        feed(3);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (err) break;
        end
        check("t6_timeout_cycles", n, 20);
        wait_done("t6");
        check("t6_err", err, 1'b1);
        check("t6_nwr", wr_log.size(), 4);
        check_write("t6_stop", 3, A_START, 32'd0);
        @(posedge clk); #1;

        // T7: reset in the middle of a transfer
        set_cfg(8'd1, 1'b1, 8'd1, 8'd0, 16'd0);
        pulse_start("t7", 1'b0);
        wait_nonseq("t7", A_MODE);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t7_rst_bus", {htrans, hwrite, haddr}, 35'h0);
        check("t7_rst_hsize", hsize, 3'b000);
        check("t7_rst_busy", busy, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("t7_idle_htrans", htrans, 2'b00);
        check("t7_idle_hsize", hsize, 3'b010);
        check("t7_idle_busy", busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lcd_frame_scheduler.md
Name: lcd_frame_scheduler

Overview:
- AHB-lite master that sequences the LCD drive interface over multiple frames.
- Per frame it programs the BR_MODE and BR_VALUE registers and writes START=1. It then counts valid pixel-pairs from the brightness datapath until the frame ends, and writes START=0.
- Between frames it waits a programmable gap and steps the brightness value.
- Sits on the system AHB bus next to the LCD drive slave; host control uses simple cmd/cfg pins.

Parameters:
- LCD_BASE, 32'h0000_0000, byte base address of the LCD drive register block.
- FRAME_PAIRS, 196608, lcd_valid pulses per frame (768*512/2).
- W_PIX_CNT, 18, width of the pixel-pair counter.
- TIMEOUT, 4095, maximum idle cycles in WAIT_FRAME before error.
- W_ADDR, 32, AHB address width.
- W_DATA, 32, AHB data width.

Ports:
- HCLK  in  1  clock
- HRESET  in  1  synchronous reset, active-high
- cmd_start  in  1  one-cycle pulse; starts a run; ignored unless IDLE
- cmd_abort  in  1  one-cycle pulse; ends the run early
- cfg_num_frames  in  8  frames per run; 0 is treated as 1
- cfg_br_mode  in  1  value written to BR_MODE
- cfg_br_start  in  8  brightness value for frame 0
- cfg_br_step  in  8  brightness increment per frame
- cfg_gap  in  16  idle cycles between frames
- lcd_valid  in  1  out_valid from the brightness datapath
- M_HREADY  in  1  AHB ready
- M_HRESP  in  2  AHB response
- M_HTRANS  out  2  AHB transfer type
- M_HADDR  out  32  AHB address
- M_HWRITE  out  1  AHB write
- M_HSIZE  out  3  AHB size
- M_HBURST  out  3  AHB burst
- M_HPROT  out  4  AHB protection
- M_HWDATA  out  32  AHB write data
- busy  out  1  high from accepted cmd_start until DONE
- done  out  1  one-cycle pulse at end of run
- err  out  1  sticky; cleared by the next accepted cmd_start
- frame_idx  out  8  index of the current frame

Behaviour:
- Reset values: all outputs 0, state IDLE. M_HTRANS = IDLE and M_HSIZE = WORD in every cycle after reset.
- Fixed AHB fields: M_HBURST = SINGLE, M_HPROT = {NOTCACHE, UNBUF, USER, DATA}.
- Register addresses: LCD_BASE + 4*idx, with START=8, BR_MODE=9, BR_VALUE=10.
- Every write is a single NONSEQ transfer with two phases:
  - Address phase: drive M_HTRANS=NONSEQ, M_HWRITE=1 and M_HADDR; hold them until a cycle with M_HREADY=1.
  - Data phase: next cycle, drive M_HTRANS=IDLE and M_HWDATA; hold it until M_HREADY=1.
  - So the minimum is 2 cycles per write.
  - If M_HRESP != OKAY in a data-phase cycle, set err and go to DONE. No START=0 write is issued.
- Next-state rules:
  - IDLE: on cmd_start, latch all cfg_*; set br=cfg_br_start, frame_idx=0, busy=1, err=0; go to WR_MODE.
  - WR_MODE: write cfg_br_mode, go to WR_VAL.
  - WR_VAL: write {24'b0, br}, go to WR_GO.
  - WR_GO: write 1 to START, go to WAIT_FRAME.
  - WAIT_FRAME: count lcd_valid cycles in pix_cnt.
    - When pix_cnt reaches FRAME_PAIRS-1 and lcd_valid=1, go to WR_STOP.
    - Idle counter resets on each lcd_valid. If it reaches TIMEOUT, set err and go to WR_STOP.
  - WR_STOP: write 0 to START.
    - Go to DONE if any of these hold: err set, abort pending, or frame_idx == num_frames-1.
    - Otherwise go to GAP.
  - GAP: count cfg_gap cycles (0 means leave next cycle). Then frame_idx+1, br = min(br+step, 255) computed with a 9-bit sum, go to WR_MODE.
  - DONE: done=1 for one cycle, busy=0, go to IDLE.
- cmd_abort:
  - In IDLE or DONE: ignored.
  - During any AHB transfer: sets abort_pend. The transfer in flight always completes; it is never dropped mid-phase.
  - In WAIT_FRAME or GAP: go to WR_STOP at once (from GAP, the STOP write is reissued; harmless). abort_pend forces WR_STOP → DONE.
- cmd_start while busy: ignored.
- cmd_start and cmd_abort in the same IDLE cycle: start wins, abort ignored.
- lcd_valid outside WAIT_FRAME: ignored; pix_cnt is cleared on entry to WAIT_FRAME.
- HRESET mid-transfer: outputs return to reset values in the next cycle; the partial bus transfer is abandoned.

Decomposition:
- Shared package/header: AHB encodings (TRANS_*, RESP_*, SIZE_WORD, BURST_SINGLE, PROT_*), the LCD drive register index constants, and the state encoding.
- Sub-module ahb_single_writer:
  - Inputs: req, addr, wdata. Outputs: ack (one pulse on data-phase completion) and resp_err.
  - Owns the address/data phase pipeline.
  - The top FSM only sequences requests.

Test Plan:
- Single frame, FRAME_PAIRS=8 (test override), HREADY=1: cmd_start, mode=1, br_start=40 → writes appear in order: 0x24←1, 0x28←40, 0x20←1, then 8 lcd_valid pulses, then 0x20←0, then done pulse. busy spans the run.
- Three frames, br_start=200, step=30, gap=5 → BR_VALUE writes 200, 230, 255 (saturated); ≥5 idle cycles between each STOP write and the next MODE write; frame_idx goes 0→1→2.
- Wait states: HREADY low for 3 cycles in the address phase and 2 in the data phase → HADDR/HTRANS held during the address stall, HWDATA held during the data stall; no duplicate write.
- HRESP=ERROR on the BR_VALUE data phase → err=1; no START write; done pulses; the next cmd_start clears err.
- Abort mid WAIT_FRAME after 3 pixels → START←0 written, done pulses; frame_idx unchanged.
- lcd_valid stuck low, TIMEOUT=20 → err set 20 cycles after the last valid, STOP write, done.
